// File: rtl/mul_div_sequencer.sv
// Iterative RV64 M-extension unit: shift-add multiply and restoring divide,
// one bit per cycle, with its own IDLE/PREP/CALC/FIX/DONE sequencer.
module mul_div_sequencer #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [1:0]   op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] result,
   output logic         div_by_zero
);

   localparam int CNT_W = $clog2(W) + 1;
   localparam logic [1:0] OP_MUL  = 2'b00;
   localparam logic [1:0] OP_MULH = 2'b01;
   localparam logic [1:0] OP_DIV  = 2'b10;
   localparam logic [1:0] OP_REM  = 2'b11;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(W - 1);

   typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

   function automatic logic [W-1:0] neg_w(input logic signed [W-1:0] x);
      return $unsigned(-x);
   endfunction

   function automatic logic [W-1:0] abs_w(input logic signed [W-1:0] x);
      return x[W-1] ? neg_w(x) : $unsigned(x);
   endfunction

   function automatic logic [2*W-1:0] neg_2w(input logic signed [2*W-1:0] x);
      return $unsigned(-x);
   endfunction

   state_t           state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic             neg_res_q, neg_res_d;
   logic             neg_rem_q, neg_rem_d;
   logic [2*W-1:0]   acc_q, acc_d;
   logic [W-1:0]     dvs_q, dvs_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]     res_q, res_d;
   logic             dbz_q, dbz_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [W-1:0]     result_q, result_d;
   logic             div_by_zero_q, div_by_zero_d;

   // Multiply step: conditional add into the upper half, then shift right
   // with the add carry entering the top bit.
   logic [W:0]       mul_sum;
   logic [2*W-1:0]   mul_next;
   assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, dvs_q};
   assign mul_next = acc_q[0] ? {mul_sum, acc_q[W-1:1]} : {1'b0, acc_q[2*W-1:1]};

   // Divide step: remainder:quotient shifted left, trial subtract; borrow
   // out of the W+1-bit difference means the divisor did not fit.
   logic [2*W:0]     div_sh;
   logic [W:0]       div_diff;
   logic [2*W-1:0]   div_next;
   assign div_sh   = {acc_q, 1'b0};
   assign div_diff = div_sh[2*W:W] - {1'b0, dvs_q};
   assign div_next = div_diff[W] ? div_sh[2*W-1:0]
                                 : {div_diff[W-1:0], div_sh[W-1:1], 1'b1};

   logic [2*W-1:0]   prod_fix;
   assign prod_fix = neg_res_q ? neg_2w(acc_q) : acc_q;

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      neg_res_d     = neg_res_q;
      neg_rem_d     = neg_rem_q;
      acc_d         = acc_q;
      dvs_d         = dvs_q;
      cnt_d         = cnt_q;
      res_d         = res_q;
      dbz_d         = dbz_q;
      busy_d        = busy_q;
      done_d        = 1'b0;
      result_d      = result_q;
      div_by_zero_d = div_by_zero_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d          = op;
               busy_d        = 1'b1;
               div_by_zero_d = 1'b0;
               acc_d         = {{W{1'b0}}, a};
               dvs_d         = b;
               cnt_d         = '0;
               neg_res_d     = 1'b0;
               neg_rem_d     = 1'b0;
               if (op[1] && (b == '0)) begin
                  res_d   = op[0] ? a : '1;
                  dbz_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  dbz_d   = 1'b0;
                  state_d = S_PREP;
               end
            end
         end
         S_PREP: begin
            // Low half of a product is sign-independent, so MUL skips abs.
            if (op_q != OP_MUL) begin
               acc_d = {{W{1'b0}}, abs_w(acc_q[W-1:0])};
               dvs_d = abs_w(dvs_q);
            end
            neg_res_d = acc_q[W-1] ^ dvs_q[W-1];
            neg_rem_d = acc_q[W-1];
            cnt_d     = '0;
            state_d   = S_CALC;
         end
         S_CALC: begin
            acc_d = op_q[1] ? div_next : mul_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ITER) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            case (op_q)
               OP_MUL:  res_d = acc_q[W-1:0];
               OP_MULH: res_d = prod_fix[2*W-1:W];
               OP_DIV:  res_d = neg_res_q ? neg_w(acc_q[W-1:0]) : acc_q[W-1:0];
               OP_REM:  res_d = neg_rem_q ? neg_w(acc_q[2*W-1:W]) : acc_q[2*W-1:W];
               default: res_d = res_q;
            endcase
            state_d = S_DONE;
         end
         S_DONE: begin
            result_d      = res_q;
            div_by_zero_d = dbz_q;
            done_d        = 1'b1;
            busy_d        = 1'b0;
            state_d       = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         op_q          <= '0;
         neg_res_q     <= 1'b0;
         neg_rem_q     <= 1'b0;
         acc_q         <= '0;
         dvs_q         <= '0;
         cnt_q         <= '0;
         res_q         <= '0;
         dbz_q         <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         result_q      <= '0;
         div_by_zero_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         neg_res_q     <= neg_res_d;
         neg_rem_q     <= neg_rem_d;
         acc_q         <= acc_d;
         dvs_q         <= dvs_d;
         cnt_q         <= cnt_d;
         res_q         <= res_d;
         dbz_q         <= dbz_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         result_q      <= result_d;
         div_by_zero_q <= div_by_zero_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign result      = result_q;
   assign div_by_zero = div_by_zero_q;

endmodule

// File: doc/mul_div_sequencer.md
Name: mul_div_sequencer

Overview:
- Iterative multiply/divide unit plus its own sequencing FSM, added beside the ALU for RV64 M-extension instructions (MUL, MULH, DIV, REM).
- The control unit pulses start from its execute state and waits in a dedicated wait state until done.
- It then writes result through a new MemToReg source.
- One operation in flight at a time; shift-add multiply and restoring divide, one bit per cycle.

Parameters:
- W, 64, operand/result width in bits (even, >= 8).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  2  00 MUL (low W bits), 01 MULH (signed x signed, high W bits), 10 DIV (signed quotient), 11 REM (signed remainder).
- a  in  W  rs1 operand; sampled with start.
- b  in  W  rs2 operand; sampled with start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; result valid.
- result  out  W  registered result; held until the next done.
- div_by_zero  out  1  valid with done; 1 if op is DIV/REM and b == 0.

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset: state IDLE, busy=0, done=0, result=0, div_by_zero=0, all internal registers 0.
- Reset wins over every other input, including mid-operation: the operation is aborted and no done is produced.
- States: IDLE, PREP, CALC, FIX, DONE. Internal registers:
  - op_r, neg_res (result negate flag), neg_rem (remainder negate flag).
  - 2W-bit accumulator/remainder, W-bit multiplicand/divisor, iteration counter of ceil(log2 W)+1 bits.
- IDLE:
  - start=1 latches op, a, b and sets busy=1.
  - If op is DIV/REM and b == 0, go directly to DONE with:
    - result = all ones for DIV, a for REM;
    - div_by_zero=1.
  - Otherwise go to PREP.
- PREP (1 cycle): convert operands to magnitudes.
  - MUL: use operands unsigned; low W bits are sign-independent.
  - MULH/DIV/REM: take absolute values of a and b.
  - neg_res = a[W-1] XOR b[W-1].
  - neg_rem = a[W-1].
  - Clear counter; go to CALC.
- CALC: exactly W cycles; counter increments each cycle; go to FIX after iteration W-1.
  - Multiply: if accumulator LSB set, add multiplicand into the upper half; then shift right by 1 (carry kept).
  - Divide: shift remainder:quotient left 1; trial subtract divisor; if non-negative, keep the difference and set quotient LSB.
- FIX (1 cycle): result selection and sign correction.
  - MUL: low W of product, no correction.
  - MULH: negate the 2W product if neg_res, take the high W.
  - DIV: quotient, negated if neg_res.
  - REM: remainder, negated if neg_rem.
  - Go to DONE.
- DONE (1 cycle): done=1, busy=0; result and div_by_zero updated in this cycle. Next state IDLE.
  - A start in the DONE cycle is ignored; start is re-sampled in IDLE the following cycle.
- Latency: start sampled at edge N gives done high after edge N+W+3 (W=64: 67 cycles).
  - Divide-by-zero path: done high after edge N+1.
- start while busy is ignored; operands may change freely while busy.
- Overflow, DIV of most-negative by -1: result = most-negative value (0x8000_0000_0000_0000). REM in the same case: 0. This falls out of the magnitude algorithm; no special case is needed.
- div_by_zero is cleared at the next accepted start.

Test Plan:
- MUL: a=7, b=-3 (0xFFFF_FFFF_FFFF_FFFD) -> done after 67 cycles, result=0xFFFF_FFFF_FFFF_FFEB (-21), div_by_zero=0.
- MULH: a=0x8000_0000_0000_0000, b=2 -> result=0xFFFF_FFFF_FFFF_FFFF. MULH a=-1, b=-1 -> result=0.
- DIV/REM: a=-7, b=2 -> DIV result=-3 (0xFFFF_FFFF_FFFF_FFFD); REM result=-1.
- DIV/REM overflow: a=0x8000_0000_0000_0000, b=-1 -> DIV result=0x8000_0000_0000_0000; REM result=0.
- Divide by zero: DIV a=5, b=0 -> done one cycle after start, result=all ones, div_by_zero=1. REM a=5, b=0 -> result=5.
- Handshake and reset:
  - start pulsed again at cycle 10 of a DIV -> ignored; exactly one done, with the original result.
  - reset asserted at cycle 30 of a MUL -> next cycle busy=0, result=0; no done pulse.
  - A new start afterward completes normally in 67 cycles.
